// File: rtl/i2s_clkgen_v.sv
// I2S master clock generator: bclk (64x fs), lrclk and a frame-start strobe, all from clk_i flops.
// Optional master clock output (256x fs) is enabled by defining I2S_MCLK_EN.
module i2s_clkgen_v #(
    parameter int BCLK_HALF = 4,
    parameter int FCNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    output logic              bclk_o,
    output logic              lrclk_o,
    output logic              sampstart_o,
    output logic              running_o,
`ifdef I2S_MCLK_EN
    output logic              mclk_o,
`endif
    output logic [FCNT_W-1:0] frame_cnt_o
);

    localparam int DIV_W = $clog2(2 * BCLK_HALF);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * BCLK_HALF - 1);
    localparam logic [DIV_W-1:0] DIV_HIGH = DIV_W'(BCLK_HALF);
    localparam logic [5:0]       BIT_LAST = 6'd63;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic             en_q;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_n;
    logic [5:0]       bit_cnt;
    logic [5:0]       bit_n;
    logic             div_end;
    logic             frame_end;
    logic             start;
    logic             run_n;
    logic             bclk_n;
    logic             lrclk_n;

    // en_i is registered once; the start/stop decision is then taken from en_q,
    // which gives the one-cycle latency from sampling en_i to the first strobe.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en_i;
        end
    end

    always_comb begin
        state_n   = state;
        div_n     = div_cnt;
        bit_n     = bit_cnt;
        start     = 1'b0;
        div_end   = (div_cnt == DIV_LAST);
        frame_end = div_end && (bit_cnt == BIT_LAST);

        case (state)
            IDLE: begin
                div_n = '0;
                bit_n = '0;
                if (en_q) begin
                    state_n = RUN;
                    start   = 1'b1;
                end
            end
            RUN, LAST: begin
                if (div_end) begin
                    div_n = '0;
                    bit_n = bit_cnt + 6'd1;
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
                // A re-request during LAST rejoins the running stream at the
                // frame boundary, so the waveform never notices the pause.
                if (frame_end && (state == LAST) && !en_q) begin
                    state_n = IDLE;
                    div_n   = '0;
                    bit_n   = '0;
                end else begin
                    state_n = en_q ? RUN : LAST;
                    start   = frame_end;
                end
            end
            default: begin
                state_n = IDLE;
                div_n   = '0;
                bit_n   = '0;
            end
        endcase

        run_n   = (state_n != IDLE);
        bclk_n  = run_n && (div_n >= DIV_HIGH);
        lrclk_n = run_n ? bit_n[5] : 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_n;
            div_cnt <= div_n;
            bit_cnt <= bit_n;
        end
    end

    // Outputs are computed from the next-state counters so each pin is a flop
    // that lines up exactly with the counter values of the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            bclk_o      <= 1'b0;
            lrclk_o     <= 1'b1;
            sampstart_o <= 1'b0;
            running_o   <= 1'b0;
            frame_cnt_o <= '0;
        end else begin
            bclk_o      <= bclk_n;
            lrclk_o     <= lrclk_n;
            sampstart_o <= start;
            running_o   <= run_n;
            if (start) begin
                frame_cnt_o <= frame_cnt_o + FCNT_W'(1);
            end
        end
    end

`ifdef I2S_MCLK_EN
    localparam int MCLK_Q = BCLK_HALF / 4;

    logic [DIV_W-1:0] mclk_phase;
    logic             mclk_n;

    always_comb begin
        mclk_phase = div_n / DIV_W'(MCLK_Q);
        mclk_n     = run_n && mclk_phase[0];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            mclk_o <= 1'b0;
        end else begin
            mclk_o <= mclk_n;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_clkgen_v.sv
// Directed bench for i2s_clkgen_v: reset, start, stop, glitchless restart and frame-end stop.
// Cycle k is the state after the k-th rising edge counted from the edge that samples en_i=1.
module tb_i2s_clkgen_v;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        bclk;
    logic        lrclk;
    logic        sampstart;
    logic        running;
    logic [15:0] frame_cnt;
`ifdef I2S_MCLK_EN
    logic        mclk;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int exp_fcnt = 0;

    i2s_clkgen_v #(.BCLK_HALF(4), .FCNT_W(16)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .en_i        (en),
        .bclk_o      (bclk),
        .lrclk_o     (lrclk),
        .sampstart_o (sampstart),
        .running_o   (running),
`ifdef I2S_MCLK_EN
        .mclk_o      (mclk),
`endif
        .frame_cnt_o (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Vector layout: {mclk, running, sampstart, lrclk, bclk}
    function automatic logic [4:0] act_vec();
        logic m;
`ifdef I2S_MCLK_EN
        m = mclk;
`else
        m = 1'b0;
`endif
        return {m, running, sampstart, lrclk, bclk};
    endfunction

    function automatic logic [4:0] idle_vec();
        return 5'b00010;
    endfunction

    function automatic logic [4:0] run_vec(int c);
        int p;
        logic [4:0] v;
        p = (c - 1) % 512;
        v[0] = ((p % 8) >= 4);
        v[1] = (p >= 256);
        v[2] = (p == 0);
        v[3] = 1'b1;
`ifdef I2S_MCLK_EN
        v[4] = ((p % 2) == 1);
`else
        v[4] = 1'b0;
`endif
        return v;
    endfunction

    task automatic test_reset();
        logic [4:0] a;
        rst_n = 1'b0;
        en = 1'b0;
        repeat (3) tick();
        total++;
        a = act_vec();
        if (a !== idle_vec()) begin
            bad++;
            $display("FAIL reset_init got=%b want=%b", a, idle_vec());
        end
        total++;
        if (frame_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_init_fcnt got=%0d want=0", frame_cnt);
        end
        rst_n = 1'b1;
        en = 1'b1;
        repeat (50) tick();
        rst_n = 1'b0;
        tick();
        total++;
        a = act_vec();
        if (a !== idle_vec()) begin
            bad++;
            $display("FAIL reset_mid got=%b want=%b", a, idle_vec());
        end
        total++;
        if (frame_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_mid_fcnt got=%0d want=0", frame_cnt);
        end
        en = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        total++;
        a = act_vec();
        if (a !== idle_vec()) begin
            bad++;
            $display("FAIL reset_release got=%b want=%b", a, idle_vec());
        end
        exp_fcnt = 0;
    endtask

    task automatic wind_down();
        en = 1'b0;
        for (int i = 0; i < 1200 && running; i++) tick();
        total++;
        if (running !== 1'b0) begin
            bad++;
            $display("FAIL wind_down_timeout got=%b want=0", running);
        end
        repeat (3) tick();
    endtask

    task automatic test_start();
        logic [4:0] a;
        logic [4:0] e;
        en = 1'b1;
        cyc = -1;
        tick();
        total++;
        a = act_vec();
        if (a !== idle_vec()) begin
            bad++;
            $display("FAIL start_cycle0 got=%b want=%b", a, idle_vec());
        end
        while (cyc < 513) begin
            tick();
            e = run_vec(cyc);
            if (cyc == 1 || cyc == 513) exp_fcnt++;
            total++;
            a = act_vec();
            if (a !== e) begin
                bad++;
                $display("FAIL start_wave cyc=%0d got=%b want=%b", cyc, a, e);
            end
            if (cyc == 1 || cyc == 513) begin
                total++;
                if (frame_cnt !== 16'(exp_fcnt)) begin
                    bad++;
                    $display("FAIL start_fcnt cyc=%0d got=%0d want=%0d", cyc, frame_cnt, exp_fcnt);
                end
            end
        end
        wind_down();
    endtask

    task automatic test_stop();
        logic [4:0] a;
        logic [4:0] e;
        en = 1'b1;
        cyc = -1;
        tick();
        while (cyc < 520) begin
            tick();
            e = (cyc <= 512) ? run_vec(cyc) : idle_vec();
            if (cyc == 1) exp_fcnt++;
            total++;
            a = act_vec();
            if (a !== e) begin
                bad++;
                $display("FAIL stop_wave cyc=%0d got=%b want=%b", cyc, a, e);
            end
            if (cyc == 513) begin
                total++;
                if (frame_cnt !== 16'(exp_fcnt)) begin
                    bad++;
                    $display("FAIL stop_fcnt got=%0d want=%0d", frame_cnt, exp_fcnt);
                end
            end
            if (cyc == 99) en = 1'b0;
        end
    endtask

    task automatic test_restart();
        logic [4:0] a;
        logic [4:0] e;
        en = 1'b1;
        cyc = -1;
        tick();
        while (cyc < 513) begin
            tick();
            e = run_vec(cyc);
            if (cyc == 1 || cyc == 513) exp_fcnt++;
            total++;
            a = act_vec();
            if (a !== e) begin
                bad++;
                $display("FAIL restart_wave cyc=%0d got=%b want=%b", cyc, a, e);
            end
            if (cyc == 99) en = 1'b0;
            if (cyc == 299) en = 1'b1;
        end
        total++;
        if (frame_cnt !== 16'(exp_fcnt)) begin
            bad++;
            $display("FAIL restart_fcnt got=%0d want=%0d", frame_cnt, exp_fcnt);
        end
        wind_down();
    endtask

    task automatic test_back_to_back();
        logic [4:0] a;
        logic [4:0] e;
        en = 1'b1;
        cyc = -1;
        tick();
        while (cyc < 1030) begin
            tick();
            e = (cyc <= 1024) ? run_vec(cyc) : idle_vec();
            if (cyc == 1 || cyc == 513) exp_fcnt++;
            total++;
            a = act_vec();
            if (a !== e) begin
                bad++;
                $display("FAIL edge_stop_wave cyc=%0d got=%b want=%b", cyc, a, e);
            end
            if (cyc == 512) en = 1'b0;
        end
        total++;
        if (frame_cnt !== 16'(exp_fcnt)) begin
            bad++;
            $display("FAIL edge_stop_fcnt got=%0d want=%0d", frame_cnt, exp_fcnt);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_stop();
        test_restart();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
